modinv_arbiter: RTL and testbench
=================================

# modinv_arbiter

Round-robin controller sharing one 256-bit binary-extended-Euclid modular inverter among `NREQ` requesters (point add/double, signature scalar inverse). Snapshots the winning requester's operand, sequences the inverter's start/busy protocol, captures the inverse and returns it with a one-cycle done pulse. Zero operands are rejected locally because the inverter never terminates on them.

## Interface
- `NREQ`, 4: number of requesters (2..8).
- `WIDTH`, 256: operand/result width; must equal the inverter width.
- `TIMEOUT_CYCLES`, 1024: abort threshold. Used only with `MODINV_ARB_TIMEOUT_EN`.

- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req` in NREQ: level request per requester; held until its `done`.
- `operand` in NREQ*WIDTH: requester i at `[i*WIDTH +: WIDTH]`; stable while `req[i]`=1.
- `grant` out NREQ: one-hot; high from acceptance through the `done` cycle.
- `done` out NREQ: one-cycle pulse to the served requester.
- `result` out WIDTH: inverse mod `prime`; valid in the `done` cycle, held until the next `done`.
- `err` out 1: pulses with `done` on zero operand or timeout. `result`=0 then.
- `inv_a` out WIDTH: registered operand to the inverter.
- `inv_start` out 1: inverter start. Low level resets the inverter asynchronously.
- `inv_b` in WIDTH: inverter result.
- `inv_busy` in 1: inverter busy.

## Operation
- States: IDLE, LAUNCH, RUN.
- IDLE, any `req` bit set: pick the first set bit searching upward from `rr_ptr`, wrapping modulo NREQ. At the edge:
  - set `grant` one-hot;
  - latch the operand into `inv_a`;
  - set `rr_ptr` = winner+1 mod NREQ.
- IDLE, selected operand == 0: no launch. Same edge drives `grant`, `done`, `err`=1 and `result`=0 for one cycle, then stay in IDLE.
- IDLE, selected operand nonzero: `inv_start`<=1, go to LAUNCH.
- LAUNCH: wait for `inv_busy`=1, then go to RUN.
- RUN: wait for `inv_busy`=0. At that edge:
  - `result`<=`inv_b`;
  - `done[winner]`<=1;
  - `inv_start`<=0;
  - go to IDLE.
- Next cycle: `grant` and `done` clear.
- `inv_start` is therefore low for at least one full cycle between operations. This guarantees the inverter is re-initialised.
- A requester deasserts `req` in the cycle after its `done`. A still-high `req` is treated as a new request. Round-robin ordering places it behind other pending requesters.
- `req` bits changing while not in IDLE are ignored until return to IDLE.
- `inv_a` is held constant from launch to `done`. Requester operand changes after acceptance have no effect.

## Timing
- Reset values:
  - `grant`=0, `done`=0, `err`=0, `result`=0;
  - `inv_a`=0, `inv_start`=0;
  - state=IDLE, `rr_ptr`=0.
- Reset mid-operation drops `inv_start` immediately, aborting the inverter. No `done` is issued.
- Zero-operand latency: `done` asserted 1 cycle after `req` is sampled.
- Nonzero latency: `req` sampled at edge 0 drives `inv_start` high. The inverter raises `busy` at edge 1. If `busy` falls at edge C, `done` is high in the cycle after edge C+1.
- Back-to-back throughput: a new launch is possible at the first IDLE edge after `done`.
- Only one requester is ever granted. `done` is never asserted without `grant` in the same cycle.

## Configuration
- `MODINV_ARB_TIMEOUT_EN` defined:
  - a counter clears at launch and counts cycles in LAUNCH/RUN;
  - when it reaches `TIMEOUT_CYCLES`: `inv_start`<=0, `result`<=0, `done`+`err` pulse, return to IDLE.
- Undefined: no counter. The arbiter waits indefinitely, and `err` reports only zero operands.

## Test plan
- Single request, with a real inverter: `req[0]`, A=2 -> `done[0]`, `result`=(prime+1)/2, `err`=0. Also A=1 -> `result`=1.
- Random nonzero A < prime on `req[2]` -> `result`*A mod prime = 1. `grant` is 4'b0100 for the whole operation, `inv_start` is low ≥1 cycle before the next launch.
- All four request at once, each dropping `req` after `done` -> service order 0,1,2,3. Then `req[0]`+`req[3]` with `rr_ptr`=0 -> 0 served before 3.
- `req[1]` with A=0 -> `grant`=`done`=4'b0010, `err`=1, `result`=0, all in the cycle after sampling. `inv_start` never rises.
- Timeout enabled, stub inverter holding `busy`=1, `TIMEOUT_CYCLES`=16 -> `err`+`done` after 16 busy cycles, `inv_start`=0, arbiter accepts the next request.
- Assert `rst_n`=0 during RUN -> `inv_start`, `grant`, `done` go to 0 immediately. After release, `req[3]` is granted first when `rr_ptr`=0 and only `req[3]` is set.

Source files
------------

// File: rtl/modinv_arbiter.sv
// Round-robin arbiter sharing one modular inverter among NREQ requesters; zero operands are rejected locally.
// Ports: req/operand in, grant/done/result/err out; inv_a/inv_start out, inv_b/inv_busy in (inverter side).
// Optional MODINV_ARB_TIMEOUT_EN: abort with err after TIMEOUT_CYCLES cycles in LAUNCH/RUN.
module modinv_arbiter #(
  parameter int NREQ           = 4,
  parameter int WIDTH          = 256,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] operand,
  output logic [NREQ-1:0]       grant,
  output logic [NREQ-1:0]       done,
  output logic [WIDTH-1:0]      result,
  output logic                  err,
  output logic [WIDTH-1:0]      inv_a,
  output logic                  inv_start,
  input  logic [WIDTH-1:0]      inv_b,
  input  logic                  inv_busy
);

  localparam int PTR_W = (NREQ > 2) ? $clog2(NREQ) : 1;

  if (NREQ < 2 || NREQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("modinv_arbiter: unsupported parameter set");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_RUN
  } state_t;

  state_t               state_q, state_d;
  logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [NREQ-1:0]      grant_q, grant_d;
  logic [NREQ-1:0]      done_q, done_d;
  logic                 err_q, err_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic [WIDTH-1:0]     inv_a_q, inv_a_d;
  logic                 inv_start_q, inv_start_d;

`ifdef MODINV_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0]     cnt_q, cnt_d;
`endif

  // (base + k) mod NREQ, with base < NREQ and k < NREQ.
  function automatic logic [PTR_W-1:0] rr_add(input logic [PTR_W-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NREQ) s = s - NREQ;
    return PTR_W'(s);
  endfunction

  // Winner search: scan offsets from high to low so the smallest offset from rr_ptr wins.
  logic                 win_found;
  logic [PTR_W-1:0]     win_idx;
  logic [NREQ-1:0]      win_oh;
  logic [WIDTH-1:0]     win_op;

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[rr_add(rr_ptr_q, k)]) begin
        win_found = 1'b1;
        win_idx   = rr_add(rr_ptr_q, k);
      end
    end
  end

  assign win_oh = NREQ'(1) << win_idx;
  assign win_op = operand[win_idx*WIDTH +: WIDTH];

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    done_d      = '0;
    err_d       = 1'b0;
    result_d    = result_q;
    inv_a_d     = inv_a_q;
    inv_start_d = inv_start_q;
`ifdef MODINV_ARB_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif

    case (state_q)
      ST_IDLE: begin
        grant_d = '0;
        if (win_found) begin
          grant_d  = win_oh;
          rr_ptr_d = rr_add(win_idx, 1);
          inv_a_d  = win_op;
          if (win_op == '0) begin
            // The inverter would never terminate on zero: answer immediately with err.
            done_d   = win_oh;
            err_d    = 1'b1;
            result_d = '0;
          end else begin
            inv_start_d = 1'b1;
            state_d     = ST_LAUNCH;
`ifdef MODINV_ARB_TIMEOUT_EN
            cnt_d       = '0;
`endif
          end
        end
      end

      ST_LAUNCH, ST_RUN: begin
        if (state_q == ST_RUN && !inv_busy) begin
          // Dropping inv_start here guarantees at least one low cycle before the next launch.
          result_d    = inv_b;
          done_d      = grant_q;
          inv_start_d = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          if (state_q == ST_LAUNCH && inv_busy) state_d = ST_RUN;
`ifdef MODINV_ARB_TIMEOUT_EN
          if (cnt_q == CNT_LAST) begin
            result_d    = '0;
            done_d      = grant_q;
            err_d       = 1'b1;
            inv_start_d = 1'b0;
            state_d     = ST_IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
`endif
        end
      end

      default: begin
        state_d     = ST_IDLE;
        grant_d     = '0;
        inv_start_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      done_q      <= '0;
      err_q       <= 1'b0;
      result_q    <= '0;
      inv_a_q     <= '0;
      inv_start_q <= 1'b0;
`ifdef MODINV_ARB_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      done_q      <= done_d;
      err_q       <= err_d;
      result_q    <= result_d;
      inv_a_q     <= inv_a_d;
      inv_start_q <= inv_start_d;
`ifdef MODINV_ARB_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign grant     = grant_q;
  assign done      = done_q;
  assign err       = err_q;
  assign result    = result_q;
  assign inv_a     = inv_a_q;
  assign inv_start = inv_start_q;

endmodule

// File: tb/tb_modinv_arbiter.sv
// Bench for modinv_arbiter: behavioural binary-Euclid inverter stub, scoreboard of expected
// done/err/result per request (expected inverses from Fermat exponentiation or constants).
// Directed steps: reset, round-robin order, single ops, zero operand, timeout (if enabled), mid-run reset.
module tb_modinv_arbiter;
  localparam int NREQ  = 4;
  localparam int WIDTH = 256;
  localparam int TO    = 16;
  localparam int LAT   = 6;
  localparam logic [WIDTH-1:0] PRIME =
    256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] operand;
  logic [NREQ-1:0]       grant;
  logic [NREQ-1:0]       done;
  logic [WIDTH-1:0]      result;
  logic                  err;
  logic [WIDTH-1:0]      inv_a;
  logic                  inv_start;
  logic [WIDTH-1:0]      inv_b = '0;
  logic                  inv_busy = 1'b0;

  always #5 clk = ~clk;

  modinv_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .operand(operand),
    .grant(grant), .done(done), .result(result), .err(err),
    .inv_a(inv_a), .inv_start(inv_start), .inv_b(inv_b), .inv_busy(inv_busy)
  );

  // Stub inverter: binary extended Euclid, busy for LAT cycles, or forever when stub_hang.
  function automatic logic [WIDTH-1:0] bin_inv(input logic [WIDTH-1:0] a);
    logic [WIDTH:0] u, v, x1, x2, p;
    if (a == '0) return '0;
    p = {1'b0, PRIME}; u = {1'b0, a}; v = p; x1 = 1; x2 = 0;
    while (u != 1 && v != 1) begin
      while (u[0] == 1'b0) begin u = u >> 1; x1 = x1[0] ? (x1 + p) >> 1 : x1 >> 1; end
      while (v[0] == 1'b0) begin v = v >> 1; x2 = x2[0] ? (x2 + p) >> 1 : x2 >> 1; end
      if (u >= v) begin u = u - v; x1 = (x1 >= x2) ? x1 - x2 : x1 + p - x2; end
      else        begin v = v - u; x2 = (x2 >= x1) ? x2 - x1 : x2 + p - x1; end
    end
    return (u == 1) ? x1[WIDTH-1:0] : x2[WIDTH-1:0];
  endfunction

  logic stub_hang = 1'b0;
  logic started   = 1'b0;
  int   scnt      = 0;

  always @(posedge clk or negedge inv_start) begin
    if (!inv_start) begin
      inv_busy <= 1'b0; started <= 1'b0; scnt <= 0;
    end else if (!started) begin
      started <= 1'b1; inv_busy <= 1'b1; scnt <= LAT; inv_b <= bin_inv(inv_a);
    end else if (inv_busy && !stub_hang) begin
      if (scnt <= 1) inv_busy <= 1'b0;
      else           scnt <= scnt - 1;
    end
  end

  // Reference inverse: a^(p-2) mod p.
  function automatic logic [WIDTH-1:0] fermat_inv(input logic [WIDTH-1:0] a);
    logic [2*WIDTH-1:0] r, b, m;
    logic [WIDTH-1:0]   e;
    r = 1; b = {{WIDTH{1'b0}}, a}; m = {{WIDTH{1'b0}}, PRIME}; e = PRIME - 2;
    for (int i = 0; i < WIDTH; i++) begin
      if (e[i]) r = (r * b) % m;
      b = (b * b) % m;
    end
    return r[WIDTH-1:0];
  endfunction

  typedef struct {
    int               idx;
    logic             err;
    logic [WIDTH-1:0] res;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic push(input int idx, input logic e, input logic [WIDTH-1:0] r);
    exp_t x;
    x.idx = idx; x.err = e; x.res = r;
    sb.push_back(x);
  endtask

  task automatic set_req(input int idx, input logic [WIDTH-1:0] a);
    operand[idx*WIDTH +: WIDTH] = a;
    req[idx] = 1'b1;
  endtask

  // Run until n dones are seen (or budget expires); each requester drops req on its done.
  task automatic serve(input int n, input int budget, input logic [NREQ-1:0] gexp,
                       output int lat, output logic start_seen);
    int   got, cyc;
    logic gbad;
    exp_t e;
    got = 0; cyc = 0; lat = 0; gbad = 1'b0; start_seen = 1'b0;
    while (got < n && cyc < budget) begin
      @(negedge clk);
      cyc++;
      start_seen = start_seen | inv_start;
      if (gexp != '0 && grant !== gexp) gbad = 1'b1;
      if (done != '0) begin
        got++;
        lat = cyc;
        if (sb.size() == 0) begin
          chk("sb_pending", WIDTH'(sb.size()), WIDTH'(1));
        end else begin
          e = sb.pop_front();
          chk("done_onehot", WIDTH'(done), WIDTH'(NREQ'(1) << e.idx));
          chk("grant_eq_done", WIDTH'(grant), WIDTH'(done));
          chk("err", WIDTH'(err), WIDTH'(e.err));
          chk("result", result, e.res);
          chk("inv_start_low_at_done", WIDTH'(inv_start), '0);
        end
        req = req & ~done;
      end
    end
    chk("serve_count", WIDTH'(got), WIDTH'(n));
    if (gexp != '0) chk("grant_held", WIDTH'(gbad), '0);
  endtask

  logic [WIDTH:0]     p1;
  logic [WIDTH-1:0]   half, ra;
  logic [2*WIDTH-1:0] prod;
  int                 lat;
  logic               ss;

  initial begin
    rst_n = 1'b0; req = '0; operand = '0;
    p1 = {1'b0, PRIME} + 1'b1;
    half = p1[WIDTH:1];

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_grant", WIDTH'(grant), '0);
    chk("rst_done", WIDTH'(done), '0);
    chk("rst_err", WIDTH'(err), '0);
    chk("rst_result", result, '0);
    chk("rst_inv_a", inv_a, '0);
    chk("rst_inv_start", WIDTH'(inv_start), '0);
    rst_n = 1'b1;
    @(negedge clk);

    // All four at once: order 0,1,2,3
    set_req(0, 2);     push(0, 1'b0, half);
    set_req(1, 1);     push(1, 1'b0, 1);
    set_req(2, 3);     push(2, 1'b0, fermat_inv(3));
    set_req(3, PRIME - 1); push(3, 1'b0, PRIME - 1);
    serve(4, 200, '0, lat, ss);

    // req[0] + req[3] with rr_ptr back at 0: 0 then 3
    set_req(0, 5);  push(0, 1'b0, fermat_inv(5));
    set_req(3, 7);  push(3, 1'b0, fermat_inv(7));
    serve(2, 100, '0, lat, ss);

    // Single request A=2, with exact latency
    set_req(0, 2);  push(0, 1'b0, half);
    serve(1, 100, 4'b0001, lat, ss);
    chk("latency_nonzero", WIDTH'(lat), WIDTH'(3 + LAT));

    // A=1
    set_req(0, 1);  push(0, 1'b0, 1);
    serve(1, 100, 4'b0001, lat, ss);

    // Random A on req[2]
    for (int i = 0; i < WIDTH / 32; i++) ra[i*32 +: 32] = $urandom;
    ra[WIDTH-1] = 1'b0;
    if (ra == '0) ra = 1;
    set_req(2, ra); push(2, 1'b0, fermat_inv(ra));
    serve(1, 100, 4'b0100, lat, ss);
    prod = ({{WIDTH{1'b0}}, result} * {{WIDTH{1'b0}}, ra}) % {{WIDTH{1'b0}}, PRIME};
    chk("inv_times_a", prod[WIDTH-1:0], 1);

    // Back-to-back relaunch: inv_start was low in the done cycle, rises at the next edge
    ra = ra ^ 256'h1234_5678;
    if (ra == '0) ra = 9;
    set_req(2, ra); push(2, 1'b0, fermat_inv(ra));
    @(negedge clk);
    chk("relaunch_inv_start", WIDTH'(inv_start), 1);
    chk("relaunch_grant", WIDTH'(grant), WIDTH'(4'b0100));
    serve(1, 100, 4'b0100, lat, ss);

    // Zero operand on req[1]
    set_req(1, '0); push(1, 1'b1, '0);
    serve(1, 20, 4'b0010, lat, ss);
    chk("latency_zero", WIDTH'(lat), 1);
    chk("zero_no_start", WIDTH'(ss), '0);

`ifdef MODINV_ARB_TIMEOUT_EN
    // Hung inverter: abort after TO cycles, then accept the next request
    stub_hang = 1'b1;
    set_req(0, 5);  push(0, 1'b1, '0);
    serve(1, 100, 4'b0001, lat, ss);
    chk("latency_timeout", WIDTH'(lat), WIDTH'(TO + 1));
    stub_hang = 1'b0;
    set_req(1, 1);  push(1, 1'b0, 1);
    serve(1, 100, 4'b0010, lat, ss);
`endif

    // Reset during RUN
    set_req(2, 7);
    repeat (4) @(negedge clk);
    chk("run_before_reset_grant", WIDTH'(grant), WIDTH'(4'b0100));
    rst_n = 1'b0;
    req = '0;
    #1;
    chk("mid_rst_inv_start", WIDTH'(inv_start), '0);
    chk("mid_rst_grant", WIDTH'(grant), '0);
    chk("mid_rst_done", WIDTH'(done), '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    set_req(3, 3);  push(3, 1'b0, fermat_inv(3));
    serve(1, 100, 4'b1000, lat, ss);
    chk("sb_drained", WIDTH'(sb.size()), '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
